// File: rtl/inst_prefetch_unit.sv
// Purpose: sequential instruction prefetcher between 1-cycle SRAM and decode.
// Latency: fetch address to inst_valid 2 cycles; redirect to inst_valid 4 cycles.
// Backpressure: inst_ready low stalls the FIFO; issue stops once credits run out.
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   mem_address/chipselect/write/byteenable/clken, mem_readdata
//                                       instruction SRAM read port
//   redirect_valid, redirect_pc         restart fetch at a new word address
//   inst_valid/ready/data/pc            instruction handshake to decode

// Generic FIFO: registered storage, head presented from the storage array.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: none internal; the caller must never push when full.
module ipf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Contents are left stale; they are unreachable once count is zero.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

  // The credit check upstream must make this impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))));
endmodule

// Purpose: top-level prefetch unit with FETCH/FLUSH control and one in-flight read.
// Latency: request in N, capture at end of N+1, inst_valid from N+2.
// Backpressure: stalled consumer fills the FIFO, then chipselect stays low.
module inst_prefetch_unit #(
  parameter int                ADDR_W   = 14,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]       data;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_use;
  fetch_ent_t        push_ent;
  fetch_ent_t        head_ent;

  assign pop = inst_valid & inst_ready;

  // Entries committed after this edge: survivors of the pop plus the word
  // returning now. A new request is allowed only if it still has a free slot.
  assign credit_use = {1'b0, fifo_count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};

  // Gated by reset so the SRAM sees no request while reset is held, even
  // though the FSM already sits in FETCH.
  assign issue = !reset && (state == ST_FETCH) && (credit_use < (CW+1)'(DEPTH));

  // A returning word is dropped during FLUSH and in the redirect cycle itself.
  assign push  = inflight && (state == ST_FETCH) && !redirect_valid;
  assign flush = redirect_valid || (state == ST_FLUSH);

  assign push_ent = '{data: mem_readdata, pc: inflight_pc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      case (state)
        ST_FETCH: begin
          if (redirect_valid) begin
            state    <= ST_FLUSH;
            fetch_pc <= redirect_pc;
          end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          // A redirect arriving here restarts the flush with the newer target.
          if (redirect_valid) fetch_pc <= redirect_pc;
          else                state    <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  ipf_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .flush    (flush),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  assign inst_valid     = (fifo_count != '0);
  assign inst_data      = head_ent.data;
  assign inst_pc        = head_ent.pc;

  assign mem_address    = fetch_pc;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Purpose: directed bench for inst_prefetch_unit with an in-order PC scoreboard.
// Latency: cycle-exact checks on issue, flush and first-valid timing.
// Backpressure: inst_ready is stalled to fill the FIFO and then released.
module tb_inst_prefetch_unit;
  localparam int ADDR_W = 14;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];

  inst_prefetch_unit #(.ADDR_W(ADDR_W), .DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [ADDR_W-1:0] a);
    return 32'h100 + {18'd0, a};
  endfunction

  // SRAM: one-cycle read latency; junk on cycles without a request.
  always @(posedge clk) mem_readdata <= mem_chipselect ? mem_val(mem_address) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("hs_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        chk("hs_pc", 32'(inst_pc), 32'(e));
        chk("hs_data", inst_data, mem_val(e));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] e;
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("mem_write", 32'(mem_write), 32'd0);
    chk("mem_be", 32'(mem_byteenable), 32'hF);
    chk("mem_clken", 32'(mem_clken), 32'd1);

    // Streaming from reset release with ready high.
    next_cycle();
    reset = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_W'(i));
    sample();
    chk("c0_cs", 32'(mem_chipselect), 32'd1);
    chk("c0_addr", 32'(mem_address), 32'd0);
    next_cycle(); sample();
    chk("c1_valid", 32'(inst_valid), 32'd0);
    chk("c1_addr", 32'(mem_address), 32'd1);
    for (int c = 2; c < 10; c++) begin
      if (c > 2) next_cycle();
      if (c == 2) next_cycle();
      sample();
      chk("stream_valid", 32'(inst_valid), 32'd1);
    end

    // One-cycle reset mid-stream; stall ready for the credit test.
    next_cycle();
    reset = 1'b1; inst_ready = 1'b0;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_cs", 32'(mem_chipselect), 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      sample();
      chk("stall_cs", 32'(mem_chipselect), (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) chk("stall_addr", 32'(mem_address), 32'(c));
      if (c >= 2) begin
        chk("stall_valid", 32'(inst_valid), 32'd1);
        chk("stall_pc", 32'(inst_pc), 32'd0);
        chk("stall_data", inst_data, mem_val('0));
      end else begin
        chk("stall_novalid", 32'(inst_valid), 32'd0);
      end
    end

    // Drain and resume (cycles 10..14), then stall to refill with PCs 5..8.
    next_cycle();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(ADDR_W'(i));
    sample();
    chk("resume_addr", 32'(mem_address), 32'd4);
    chk("resume_cs", 32'(mem_chipselect), 32'd1);
    for (int c = 11; c < 15; c++) begin
      next_cycle(); sample();
      chk("drain_valid", 32'(inst_valid), 32'd1);
    end
    next_cycle();
    inst_ready = 1'b0;
    sample();
    chk("full_no_issue", 32'(mem_chipselect), 32'd0);
    next_cycle(); sample();
    chk("full_pc", 32'(inst_pc), 32'd5);
    chk("full_cs", 32'(mem_chipselect), 32'd0);

    // Redirect to 0x2A0 while PC 5 is accepted and PC 9 is being requested.
    next_cycle();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 14'h2A0;
    sample();
    chk("redir_pc5", 32'(inst_pc), 32'd5);
    chk("redir_req9", 32'(mem_address), 32'd9);
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_cs", 32'(mem_chipselect), 32'd0);
    next_cycle();
    exp_q.push_back(14'h2A0); exp_q.push_back(14'h2A1); exp_q.push_back(14'h2A2);
    sample();
    chk("r2_addr", 32'(mem_address), 32'h2A0);
    chk("r2_valid", 32'(inst_valid), 32'd0);
    next_cycle(); sample();
    chk("r3_valid", 32'(inst_valid), 32'd0);
    next_cycle(); sample();
    chk("r4_valid", 32'(inst_valid), 32'd1);
    chk("r4_pc", 32'(inst_pc), 32'h2A0);
    next_cycle(); sample();
    chk("r5_pc", 32'(inst_pc), 32'h2A1);

    // Redirect to 0x3FFE: PCs must wrap to 0 and continue up to 12.
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 14'h3FFE;
    sample();
    chk("q_pc", 32'(inst_pc), 32'h2A2);
    next_cycle();
    redirect_valid = 1'b0;
    exp_q.push_back(14'h3FFE); exp_q.push_back(14'h3FFF);
    for (int i = 0; i <= 12; i++) exp_q.push_back(ADDR_W'(i));
    sample();
    chk("q1_valid", 32'(inst_valid), 32'd0);
    next_cycle(); sample();
    chk("q2_addr", 32'(mem_address), 32'h3FFE);
    next_cycle(); sample();
    chk("q3_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 14; k++) begin
      next_cycle(); sample();
      e = 14'h3FFE + ADDR_W'(k);
      chk("wrap_pc", 32'(inst_pc), 32'(e));
    end

    // Redirect in the same cycle PC 12 is accepted: 13 must never appear.
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 14'h155;
    sample();
    chk("s_pc12", 32'(inst_pc), 32'd12);
    chk("s_valid", 32'(inst_valid), 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
    exp_q.push_back(14'h155); exp_q.push_back(14'h156);
    sample();
    chk("s1_valid", 32'(inst_valid), 32'd0);
    next_cycle(); sample();
    chk("s2_addr", 32'(mem_address), 32'h155);
    next_cycle(); sample();
    chk("s3_valid", 32'(inst_valid), 32'd0);
    next_cycle(); sample();
    chk("s4_pc", 32'(inst_pc), 32'h155);
    next_cycle(); sample();
    chk("s5_pc", 32'(inst_pc), 32'h156);
    next_cycle();
    inst_ready = 1'b0;
    repeat (4) next_cycle();
    sample();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("hs_count", 32'(hs_cnt), 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Fetch-side stage directly upstream of the on-chip instruction memory (single-port SRAM: 32-bit words, 14-bit word address, 1-cycle read latency).
- Drives sequential word addresses into the memory and captures the returned words into a small prefetch FIFO.
- Presents instruction+PC to the CPU decode stage over a valid/ready handshake.
- Supports redirect (branch/jump/exception): flushes buffered and in-flight fetches, then restarts at a new PC.

Parameters:
- ADDR_W, 14, word-address width; PC counts words, modulo 2^ADDR_W.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 0, word address fetched first after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_address  out  ADDR_W  word address to instruction memory.
- mem_chipselect  out  1  read request qualifier.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  32  memory data; valid the cycle after a request.
- redirect_valid  in  1  single-cycle pulse to restart fetch.
- redirect_pc  in  ADDR_W  new fetch word address.
- inst_valid  out  1  inst_data/inst_pc hold a valid instruction.
- inst_ready  in  1  consumer accepts the instruction this cycle.
- inst_data  out  32  instruction word at FIFO head.
- inst_pc  out  ADDR_W  word address of inst_data.

Behaviour:
- Reset (async assert, sync deassert from the system reset controller) clears state:
  - fetch_pc=RESET_PC, FIFO empty, inflight=0, state=FETCH.
  - mem_chipselect=0, inst_valid=0, inst_data=0, inst_pc=0, mem_address=RESET_PC.
- Memory timing: request issued in cycle N (mem_chipselect=1, mem_address=A) returns mem_readdata=M[A] in cycle N+1. No waitrequest. At most one request in flight.
- Issue rule: issue in a cycle iff state=FETCH and (occupancy + inflight) < DEPTH, where occupancy excludes an entry popped this cycle. On issue, fetch_pc <= fetch_pc+1 (wraps 2^ADDR_W-1 -> 0). The PC of each request is carried alongside it.
- Capture: in cycle N+1 the returned word and its PC are written into the FIFO on the closing edge, unless discarded. Earliest inst_valid is N+2.
- From reset release: address RESET_PC in cycle 0; inst_valid=1 with inst_pc=RESET_PC in cycle 2. With inst_ready held high, one instruction per cycle thereafter.
- Output: inst_data/inst_pc driven from the FIFO head register. Pop occurs when inst_valid & inst_ready. While inst_valid=1 and inst_ready=0, outputs are held stable.
- Simultaneous push and pop: occupancy unchanged; ordering preserved.
- FIFO full: no issue; the credit rule guarantees no overflow. Push to a full FIFO is an assertion failure.
- FSM:
  - FETCH: normal issue/capture. Go to FLUSH on redirect_valid.
  - FLUSH (exactly 1 cycle): FIFO cleared, inst_valid=0, no issue, fetch_pc=redirect_pc. Any response arriving this cycle is dropped. Next state FETCH.
  - FLUSH then FETCH: first issue at redirect_pc in the cycle after FLUSH.
  - Redirect in cycle R: FLUSH in R+1, address redirect_pc in R+2, inst_valid in R+4.
- Redirect in the same cycle as a handshake: the handshake completes (that instruction counts as consumed), then the flush occurs.
- Redirect in the same cycle as a returning response: that response is discarded.
- Redirect while in FLUSH: latest redirect_pc wins; FLUSH extends by one cycle.
- Reset mid-operation: immediate return to reset values. In-flight data is ignored.

Test Plan:
- Reset release, M[0..7]=0x100+i, inst_ready=1 -> inst_valid first in cycle 2. inst_pc 0,1,2,... with data 0x100,0x101,... one per cycle, no gaps.
- inst_ready=0 for 10 cycles after start -> exactly DEPTH=4 words buffered. mem_chipselect stays 0 once credits are exhausted. Outputs hold PC 0. On ready=1, PCs 0..3 drain, then fetch resumes at 4 with no loss or duplication.
- Redirect pulse to 0x2A0 while FIFO holds PCs 5..8 and a request for 9 is in flight -> 9 is discarded. Next inst_pc=0x2A0 exactly 4 cycles after the pulse, followed by 0x2A1.
- Redirect to 0x3FFE (ADDR_W=14) -> sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Redirect coincident with inst_valid&inst_ready at PC 12 -> PC 12 is consumed once, and PC 13 is never presented.
- Assert reset for 1 cycle mid-stream -> inst_valid=0 and mem_chipselect=0 immediately. Fetch restarts at RESET_PC, first inst_valid 2 cycles after deassertion.
